// File: rtl/router_pkg.sv
// Shared constants for the router output buffer: widths, depth and the
// header byte field positions used by the read-side length tracker.
package router_pkg;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 7;

  // Header byte layout: [7:2] payload length, [1:0] destination address.
  localparam int HDR_LEN_MSB  = 7;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_ADDR_MSB = 1;
  localparam int HDR_ADDR_LSB = 0;

endpackage

// File: rtl/router_fifo_mem.sv
// Storage array for one router output buffer. Each entry is a data byte plus a
// header tag bit at the top. Writes land on the clock edge; reads are
// combinational so the top level can register the selected byte itself.
module router_fifo_mem
  import router_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W:0]   wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W:0]   rdata
);

  logic [DATA_W:0] mem [DEPTH];

  // Store the tagged byte at the write address when enabled; no reset, contents are don't-care.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/router_fifo.sv
// Per-port output buffer of the 1x3 router. Holds tagged bytes, reports
// full/empty to the synchroniser and tracks how much of the current packet is
// still to be read so the output side knows when a packet is in flight.
//
// Handshake: a write_en beat is accepted only when full is low and a read_en
// beat only when empty is low, both judged on the flag values before the edge.
// A beat that is not accepted is dropped with no side effects; the sender
// must present it again.
module router_fifo
  import router_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              soft_rst,
  input  logic              write_en,
  input  logic              read_en,
  input  logic              lfd_state,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty,
  output logic              pkt_busy
);

  logic [ADDR_W:0]  wr_ptr;
  logic [ADDR_W:0]  rd_ptr;
  logic [CNT_W-1:0] rd_cnt;
  logic [DATA_W:0]  rd_word;
  logic             wr_ok;
  logic             rd_ok;
  logic             clear;

  // Extra pointer MSB distinguishes a full buffer from an empty one.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

  assign clear    = rst | soft_rst;
  assign wr_ok    = write_en & ~full;
  assign rd_ok    = read_en & ~empty;
  assign pkt_busy = (rd_cnt != '0);

  router_fifo_mem u_mem (
    .clk   (clk),
    .we    (wr_ok & ~clear),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata ({lfd_state, data_in}),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (rd_word)
  );

  // Pointer advance, registered read data and packet length tracking.
  // rst and soft_rst clear to the same values, so rst winning is implicit.
  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_cnt   <= '0;
      data_out <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr   <= rd_ptr + 1'b1;
        data_out <= rd_word[DATA_W-1:0];
        if (rd_word[DATA_W]) begin
          // Header: payload length plus the trailing parity byte.
          rd_cnt <= CNT_W'(rd_word[HDR_LEN_MSB:HDR_LEN_LSB]) + 1'b1;
        end else if (rd_cnt != '0) begin
          rd_cnt <= rd_cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_router_fifo.sv
// Directed bench for router_fifo: each scenario task drives its stimulus and
// checks outputs inline against hand-computed values.
module tb_router_fifo;

  logic       clk;
  logic       rst;
  logic       soft_rst;
  logic       write_en;
  logic       read_en;
  logic       lfd_state;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       full;
  logic       empty;
  logic       pkt_busy;

  int total;
  int bad;

  logic [7:0] exp_q[$];

  router_fifo dut (
    .clk       (clk),
    .rst       (rst),
    .soft_rst  (soft_rst),
    .write_en  (write_en),
    .read_en   (read_en),
    .lfd_state (lfd_state),
    .data_in   (data_in),
    .data_out  (data_out),
    .full      (full),
    .empty     (empty),
    .pkt_busy  (pkt_busy)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] d, input logic tag);
    write_en  = 1'b1;
    data_in   = d;
    lfd_state = tag;
    step();
    write_en  = 1'b0;
    lfd_state = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    soft_rst = 1'b0; write_en = 1'b0; read_en = 1'b0; lfd_state = 1'b0; data_in = 8'h00;
    do_reset();
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", full); end
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", data_out); end
    total++; if (pkt_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", pkt_busy); end
  endtask

  task automatic test_packet();
    logic [7:0] exp_d;
    logic       exp_b[5];
    exp_b = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};  // rd_cnt 4,3,2,1,0
    exp_q = {8'h0C, 8'hA1, 8'hA2, 8'hA3, 8'h5F};
    do_write(8'h0C, 1'b1);
    do_write(8'hA1, 1'b0);
    do_write(8'hA2, 1'b0);
    do_write(8'hA3, 1'b0);
    do_write(8'h5F, 1'b0);
    total++; if (pkt_busy !== 1'b0) begin bad++; $display("FAIL pkt_busy_before_read got=%b want=0", pkt_busy); end
    for (int i = 0; i < 5; i++) begin
      exp_d = exp_q.pop_front();
      read_en = 1'b1;
      step();
      read_en = 1'b0;
      total++; if (data_out !== exp_d) begin bad++; $display("FAIL pkt_data[%0d] got=%h want=%h", i, data_out, exp_d); end
      total++; if (pkt_busy !== exp_b[i]) begin bad++; $display("FAIL pkt_busy[%0d] got=%b want=%b", i, pkt_busy, exp_b[i]); end
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL pkt_empty got=%b want=1", empty); end
  endtask

  task automatic test_full();
    logic [7:0] exp_d;
    for (int i = 0; i < 16; i++) begin
      total++; if (full !== 1'b0) begin bad++; $display("FAIL full_early[%0d] got=%b want=0", i, full); end
      do_write(8'h10 + 8'(i), 1'b0);
      exp_q.push_back(8'h10 + 8'(i));
    end
    total++; if (full !== 1'b1) begin bad++; $display("FAIL full_after16 got=%b want=1", full); end
    do_write(8'hEE, 1'b0);
    total++; if (full !== 1'b1) begin bad++; $display("FAIL full_after17 got=%b want=1", full); end
    for (int i = 0; i < 16; i++) begin
      exp_d = exp_q.pop_front();
      read_en = 1'b1;
      step();
      read_en = 1'b0;
      total++; if (data_out !== exp_d) begin bad++; $display("FAIL full_data[%0d] got=%h want=%h", i, data_out, exp_d); end
      total++; if (pkt_busy !== 1'b0) begin bad++; $display("FAIL full_busy[%0d] got=%b want=0", i, pkt_busy); end
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL full_drain_empty got=%b want=1", empty); end
    read_en = 1'b1;
    step();
    read_en = 1'b0;
    total++; if (data_out !== 8'h1F) begin bad++; $display("FAIL empty_read_hold got=%h want=1f", data_out); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL empty_read_empty got=%b want=1", empty); end
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp_d;
    for (int i = 0; i < 16; i++) do_write(8'h20 + 8'(i), 1'b0);
    total++; if (full !== 1'b1) begin bad++; $display("FAIL sim_full got=%b want=1", full); end
    write_en = 1'b1; read_en = 1'b1; data_in = 8'h99;
    step();
    write_en = 1'b0; read_en = 1'b0;
    total++; if (data_out !== 8'h20) begin bad++; $display("FAIL sim_full_data got=%h want=20", data_out); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL sim_full_flag got=%b want=0", full); end
    for (int i = 1; i < 16; i++) exp_q.push_back(8'h20 + 8'(i));
    for (int i = 1; i < 16; i++) begin
      exp_d = exp_q.pop_front();
      read_en = 1'b1;
      step();
      read_en = 1'b0;
      total++; if (data_out !== exp_d) begin bad++; $display("FAIL sim_drain[%0d] got=%h want=%h", i, data_out, exp_d); end
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL sim_drain_empty got=%b want=1", empty); end
    write_en = 1'b1; read_en = 1'b1; data_in = 8'h77;
    step();
    write_en = 1'b0; read_en = 1'b0;
    total++; if (data_out !== 8'h2F) begin bad++; $display("FAIL sim_empty_data got=%h want=2f", data_out); end
    total++; if (empty !== 1'b0) begin bad++; $display("FAIL sim_empty_flag got=%b want=0", empty); end
    read_en = 1'b1;
    step();
    read_en = 1'b0;
    total++; if (data_out !== 8'h77) begin bad++; $display("FAIL sim_empty_read got=%h want=77", data_out); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL sim_empty_final got=%b want=1", empty); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_d;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 10; i++) begin
        do_write(8'h40 + 8'(16 * r) + 8'(i), 1'b0);
        exp_q.push_back(8'h40 + 8'(16 * r) + 8'(i));
      end
      for (int i = 0; i < 10; i++) begin
        exp_d = exp_q.pop_front();
        read_en = 1'b1;
        step();
        read_en = 1'b0;
        total++; if (data_out !== exp_d) begin bad++; $display("FAIL wrap[%0d][%0d] got=%h want=%h", r, i, data_out, exp_d); end
      end
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL wrap_empty got=%b want=1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL wrap_full got=%b want=0", full); end
  endtask

  task automatic test_soft_rst();
    logic [7:0] exp_d;
    logic       exp_b[4];
    do_write(8'h0C, 1'b1);
    do_write(8'hB1, 1'b0);
    do_write(8'hB2, 1'b0);
    do_write(8'hB3, 1'b0);
    read_en = 1'b1;
    step();
    step();
    read_en = 1'b0;
    total++; if (data_out !== 8'hB1) begin bad++; $display("FAIL soft_pre_data got=%h want=b1", data_out); end
    total++; if (pkt_busy !== 1'b1) begin bad++; $display("FAIL soft_pre_busy got=%b want=1", pkt_busy); end
    soft_rst = 1'b1; write_en = 1'b1; read_en = 1'b1; data_in = 8'hDD;
    step();
    soft_rst = 1'b0; write_en = 1'b0; read_en = 1'b0;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL soft_empty got=%b want=1", empty); end
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL soft_data got=%h want=00", data_out); end
    total++; if (pkt_busy !== 1'b0) begin bad++; $display("FAIL soft_busy got=%b want=0", pkt_busy); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL soft_full got=%b want=0", full); end
    // New header length 2: counter goes 3,2,1,0 over header, two payload, parity.
    exp_b = '{1'b1, 1'b1, 1'b1, 1'b0};
    exp_q = {8'h08, 8'hC1, 8'hC2, 8'hCF};
    do_write(8'h08, 1'b1);
    do_write(8'hC1, 1'b0);
    do_write(8'hC2, 1'b0);
    do_write(8'hCF, 1'b0);
    for (int i = 0; i < 4; i++) begin
      exp_d = exp_q.pop_front();
      read_en = 1'b1;
      step();
      read_en = 1'b0;
      total++; if (data_out !== exp_d) begin bad++; $display("FAIL soft_new_data[%0d] got=%h want=%h", i, data_out, exp_d); end
      total++; if (pkt_busy !== exp_b[i]) begin bad++; $display("FAIL soft_new_busy[%0d] got=%b want=%b", i, pkt_busy, exp_b[i]); end
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL soft_new_empty got=%b want=1", empty); end
  endtask

  task automatic test_rst_priority();
    do_write(8'h0C, 1'b1);
    read_en = 1'b1;
    step();
    read_en = 1'b0;
    rst = 1'b1; soft_rst = 1'b1;
    step();
    rst = 1'b0; soft_rst = 1'b0;
    total++; if (pkt_busy !== 1'b0) begin bad++; $display("FAIL prio_busy got=%b want=0", pkt_busy); end
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL prio_data got=%h want=00", data_out); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL prio_empty got=%b want=1", empty); end
  endtask

  // Scenario sequence and final report.
  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    test_reset();
    test_packet();
    test_full();
    test_simultaneous();
    test_wrap();
    test_soft_rst();
    test_rst_priority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
